// File: rtl/usb_pkg.sv
// Shared encodings for the USB endpoint arbiter: handshake codes, FSM states
// and the default maximum IN payload size.
package usb_pkg;

  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NAK   = 2'b01,
    HS_STALL = 2'b10,
    HS_NONE  = 2'b11
  } handshake_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IN_DATA  = 2'b01,
    ST_OUT_DATA = 2'b10,
    ST_WAIT_END = 2'b11
  } state_t;

  localparam int MAX_PKT_DEFAULT = 64;

endpackage

// File: rtl/usb_ep_arbiter.sv
// Routes one USB transaction at a time between the protocol core and NUM_EP
// endpoints: chooses the handshake, moves payload bytes and keeps data toggles.
module usb_ep_arbiter
  import usb_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = MAX_PKT_DEFAULT
) (
  input  logic                clk_48,
  input  logic                rst,
  input  logic                usb_rst,
  input  logic                transaction_active,
  input  logic [3:0]          endpoint,
  input  logic                direction_in,
  input  logic                setup,
  input  logic [7:0]          data_out,
  input  logic                data_strobe,
  input  logic                success,
  output logic                data_toggle,
  output logic [1:0]          handshake,
  output logic [7:0]          data_in,
  output logic                data_in_valid,
  input  logic [NUM_EP-1:0]   ep_stall,
  input  logic [NUM_EP-1:0]   in_valid,
  input  logic [8*NUM_EP-1:0] in_data,
  output logic [NUM_EP-1:0]   in_strobe,
  input  logic [NUM_EP-1:0]   out_ready,
  output logic [7:0]          out_data,
  output logic [NUM_EP-1:0]   out_strobe,
  output logic [NUM_EP-1:0]   out_commit,
  output logic [NUM_EP-1:0]   out_abort,
  output logic                out_setup
);

  localparam int CNT_W = $clog2(MAX_PKT + 1);

  state_t            state_q, state_d;
  handshake_t        handshake_q, handshake_d;
  logic              data_toggle_q, data_toggle_d;
  logic [3:0]        ep_q, ep_d;
  logic              dir_in_q, dir_in_d;
  logic              setup_q, setup_d;
  logic [NUM_EP-1:0] toggle_in_q, toggle_in_d;
  logic [NUM_EP-1:0] toggle_out_q, toggle_out_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              eop_q, eop_d;
  logic              strobed_q, strobed_d;
  logic              acked_q, acked_d;
  logic              ta_prev_q;

  logic              bus_reset;
  logic              txn_live;
  logic              in_go;
  logic              out_go;
  logic              in_avail;
  logic              ta_rise;
  logic              ta_fall;
  logic [NUM_EP-1:0] new_sel;
  logic [NUM_EP-1:0] cur_sel;
  logic [7:0]        in_byte;
  handshake_t        new_hs;

  // One-hot decode of the incoming and latched endpoint; an out-of-range
  // number decodes to all zeros so it can never strobe anything.
  always_comb begin
    new_sel = '0;
    cur_sel = '0;
    in_byte = 8'h00;
    for (int i = 0; i < NUM_EP; i++) begin
      new_sel[i] = (endpoint == 4'(i));
      cur_sel[i] = (ep_q == 4'(i));
      if (ep_q == 4'(i)) in_byte = in_data[8*i +: 8];
    end
  end

  always_comb begin
    new_hs = HS_ACK;
    if (new_sel == '0)                                 new_hs = HS_STALL;
    else if (|(ep_stall & new_sel) && !setup)          new_hs = HS_STALL;
    else if (direction_in && !(|(in_valid & new_sel))) new_hs = HS_NAK;
    else if (!direction_in && !(|(out_ready & new_sel))) new_hs = HS_NAK;
  end

  assign bus_reset = rst | usb_rst;
  assign ta_rise   = transaction_active && !ta_prev_q;
  assign ta_fall   = (state_q != ST_IDLE) && !transaction_active;
  assign txn_live  = (state_q != ST_IDLE) && (handshake_q == HS_ACK) && !bus_reset;
  assign in_go     = txn_live && (state_q == ST_IN_DATA);
  assign out_go    = txn_live && (state_q == ST_OUT_DATA);
  assign in_avail  = in_go && !eop_q && |(in_valid & cur_sel) &&
                     (byte_cnt_q < CNT_W'(MAX_PKT));

  assign handshake     = handshake_q;
  assign data_toggle   = data_toggle_q;
  assign data_in       = in_avail ? in_byte : 8'h00;
  assign data_in_valid = in_avail;
  assign in_strobe     = (in_avail && data_strobe) ? cur_sel : '0;
  assign out_data      = out_go ? data_out : 8'h00;
  assign out_strobe    = (out_go && data_strobe) ? cur_sel : '0;
  assign out_commit    = (txn_live && !dir_in_q && success) ? cur_sel : '0;
  assign out_setup     = txn_live && !dir_in_q && success && setup_q;
  assign out_abort     = (txn_live && !dir_in_q && ta_fall && !acked_q && !success && strobed_q)
                         ? cur_sel : '0;

  always_comb begin
    state_d       = state_q;
    handshake_d   = handshake_q;
    data_toggle_d = data_toggle_q;
    ep_d          = ep_q;
    dir_in_d      = dir_in_q;
    setup_d       = setup_q;
    toggle_in_d   = toggle_in_q;
    toggle_out_d  = toggle_out_q;
    byte_cnt_d    = byte_cnt_q;
    eop_d         = eop_q;
    strobed_d     = strobed_q;
    acked_d       = acked_q;

    case (state_q)
      ST_IDLE: begin
        if (ta_rise) begin
          ep_d          = endpoint;
          dir_in_d      = direction_in;
          setup_d       = setup;
          handshake_d   = new_hs;
          data_toggle_d = direction_in ? |(toggle_in_q & new_sel) : |(toggle_out_q & new_sel);
          byte_cnt_d    = '0;
          eop_d         = 1'b0;
          strobed_d     = 1'b0;
          acked_d       = 1'b0;
          state_d       = direction_in ? ST_IN_DATA : ST_OUT_DATA;
        end
      end
      ST_IN_DATA: begin
        if (handshake_q != HS_ACK) state_d = ST_WAIT_END;
        if (in_avail && data_strobe) byte_cnt_d = byte_cnt_q + CNT_W'(1);
        if (in_go && !in_avail) eop_d = 1'b1;
      end
      ST_OUT_DATA: begin
        if (handshake_q != HS_ACK) state_d = ST_WAIT_END;
        if (out_go && data_strobe) strobed_d = 1'b1;
      end
      default: ;
    endcase

    // A successful SETUP to EP0 restarts both directions at DATA1.
    if (txn_live && success) begin
      acked_d = 1'b1;
      if (setup_q && ep_q == 4'd0) begin
        toggle_in_d[0]  = 1'b1;
        toggle_out_d[0] = 1'b1;
      end else if (dir_in_q) begin
        toggle_in_d = toggle_in_q ^ cur_sel;
      end else begin
        toggle_out_d = toggle_out_q ^ cur_sel;
      end
    end

    if (ta_fall) begin
      state_d       = ST_IDLE;
      handshake_d   = HS_NONE;
      data_toggle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_48) begin
    ta_prev_q <= transaction_active;
    if (rst || usb_rst) begin
      state_q       <= ST_IDLE;
      handshake_q   <= HS_NONE;
      data_toggle_q <= 1'b0;
      ep_q          <= 4'd0;
      dir_in_q      <= 1'b0;
      setup_q       <= 1'b0;
      toggle_in_q   <= '0;
      toggle_out_q  <= '0;
      byte_cnt_q    <= '0;
      eop_q         <= 1'b0;
      strobed_q     <= 1'b0;
      acked_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      handshake_q   <= handshake_d;
      data_toggle_q <= data_toggle_d;
      ep_q          <= ep_d;
      dir_in_q      <= dir_in_d;
      setup_q       <= setup_d;
      toggle_in_q   <= toggle_in_d;
      toggle_out_q  <= toggle_out_d;
      byte_cnt_q    <= byte_cnt_d;
      eop_q         <= eop_d;
      strobed_q     <= strobed_d;
      acked_q       <= acked_d;
    end
  end

endmodule

// File: tb/tb_usb_ep_arbiter.sv
// Bench for usb_ep_arbiter: directed and randomized transactions checked
// against a transaction-level model of handshakes, byte flow and toggles.
module tb_usb_ep_arbiter;

  localparam int NUM_EP  = 4;
  localparam int MAX_PKT = 64;
  localparam logic [1:0] ACK = 2'b00, NAK = 2'b01, STALL = 2'b10, NONE = 2'b11;

  logic                clk_48 = 1'b0;
  logic                rst = 1'b1;
  logic                usb_rst = 1'b0;
  logic                transaction_active = 1'b0;
  logic [3:0]          endpoint = 4'd0;
  logic                direction_in = 1'b0;
  logic                setup = 1'b0;
  logic [7:0]          data_out = 8'h00;
  logic                data_strobe = 1'b0;
  logic                success = 1'b0;
  logic                data_toggle;
  logic [1:0]          handshake;
  logic [7:0]          data_in;
  logic                data_in_valid;
  logic [NUM_EP-1:0]   ep_stall = '0;
  logic [NUM_EP-1:0]   in_valid = '0;
  logic [8*NUM_EP-1:0] in_data = '0;
  logic [NUM_EP-1:0]   in_strobe;
  logic [NUM_EP-1:0]   out_ready = '0;
  logic [7:0]          out_data;
  logic [NUM_EP-1:0]   out_strobe;
  logic [NUM_EP-1:0]   out_commit;
  logic [NUM_EP-1:0]   out_abort;
  logic                out_setup;

  int checks = 0;
  int failures = 0;
  bit tog_in [NUM_EP];
  bit tog_out[NUM_EP];
  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  int strobe_cnt;
  int stray_cnt;
  logic [NUM_EP-1:0] commit_obs;
  logic [NUM_EP-1:0] abort_obs;
  logic setup_obs;

  usb_ep_arbiter #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT)) dut (
    .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst),
    .transaction_active(transaction_active), .endpoint(endpoint),
    .direction_in(direction_in), .setup(setup), .data_out(data_out),
    .data_strobe(data_strobe), .success(success), .data_toggle(data_toggle),
    .handshake(handshake), .data_in(data_in), .data_in_valid(data_in_valid),
    .ep_stall(ep_stall), .in_valid(in_valid), .in_data(in_data),
    .in_strobe(in_strobe), .out_ready(out_ready), .out_data(out_data),
    .out_strobe(out_strobe), .out_commit(out_commit), .out_abort(out_abort),
    .out_setup(out_setup)
  );

  always #5 clk_48 = ~clk_48;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transaction-level reference model.
  function automatic logic [1:0] exp_hs(int ep, bit dir, bit stp);
    if (ep >= NUM_EP) return STALL;
    if (ep_stall[ep] && !stp) return STALL;
    if (dir) return in_valid[ep] ? ACK : NAK;
    return out_ready[ep] ? ACK : NAK;
  endfunction

  function automatic bit exp_tog(int ep, bit dir);
    if (ep >= NUM_EP) return 1'b0;
    return dir ? tog_in[ep] : tog_out[ep];
  endfunction

  function automatic void model_success(int ep, bit dir, bit stp);
    if (stp && ep == 0) begin
      tog_in[0]  = 1'b1;
      tog_out[0] = 1'b1;
    end else if (dir) tog_in[ep] = !tog_in[ep];
    else tog_out[ep] = !tog_out[ep];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_EP; i++) begin
      tog_in[i]  = 1'b0;
      tog_out[i] = 1'b0;
    end
  endfunction

  function automatic logic [NUM_EP-1:0] onehot(int ep);
    logic [NUM_EP-1:0] one;
    one = NUM_EP'(1);
    return (ep < NUM_EP) ? (one << ep) : '0;
  endfunction

  function automatic bit got_matches(int n);
    if (got_q.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) if (got_q[i] !== src_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic start_txn(input int ep, input bit dir, input bit stp);
    endpoint = 4'(ep);
    direction_in = dir;
    setup = stp;
    transaction_active = 1'b1;
    tick();
  endtask

  // Acts as the IN endpoint, serving src_q while the core strobes every cycle.
  task automatic drive_in(input int ep);
    int idx = 0;
    got_q.delete();
    strobe_cnt = 0;
    stray_cnt = 0;
    for (int k = 0; k < MAX_PKT + 16; k++) begin
      if (ep < NUM_EP) begin
        in_valid[ep] = (idx < src_q.size());
        in_data[8*ep +: 8] = (idx < src_q.size()) ? src_q[idx] : 8'h00;
      end
      data_strobe = 1'b1;
      @(negedge clk_48);
      if (!data_in_valid) begin
        if (in_strobe != '0) stray_cnt++;
        data_strobe = 1'b0;
        tick();
        break;
      end
      got_q.push_back(data_in);
      if (in_strobe != '0) strobe_cnt++;
      if (in_strobe != onehot(ep)) stray_cnt++;
      if (ep < NUM_EP && in_strobe[ep]) idx++;
      tick();
    end
    data_strobe = 1'b0;
  endtask

  task automatic drive_out(input int ep, input int n, input bit acked);
    got_q.delete();
    strobe_cnt = 0;
    stray_cnt = 0;
    for (int i = 0; i < n; i++) begin
      data_out = src_q[i];
      data_strobe = 1'b1;
      @(negedge clk_48);
      if (out_strobe != '0) begin
        strobe_cnt++;
        got_q.push_back(out_data);
      end
      if (out_strobe != (acked ? onehot(ep) : '0)) stray_cnt++;
      tick();
    end
    data_strobe = 1'b0;
  endtask

  task automatic finish_txn(input bit succ);
    commit_obs = '0;
    abort_obs = '0;
    setup_obs = 1'b0;
    if (succ) begin
      success = 1'b1;
      @(negedge clk_48);
      commit_obs = out_commit;
      setup_obs = out_setup;
      tick();
      success = 1'b0;
    end
    transaction_active = 1'b0;
    @(negedge clk_48);
    abort_obs = out_abort;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    @(negedge clk_48);
    checks++; if (handshake !== NONE) begin failures++; $display("[TB] FAIL reset_hs: got %b expected %b", handshake, NONE); end
    checks++; if (data_toggle !== 1'b0) begin failures++; $display("[TB] FAIL reset_toggle: got %b expected 0", data_toggle); end
    checks++; if ({data_in_valid, data_in} !== 9'h000) begin failures++; $display("[TB] FAIL reset_data_in: got %h expected 000", {data_in_valid, data_in}); end
    checks++; if ({in_strobe, out_strobe, out_commit, out_abort, out_setup} !== '0) begin failures++; $display("[TB] FAIL reset_pulses: got %h expected 0", {in_strobe, out_strobe, out_commit, out_abort, out_setup}); end
    tick();
  endtask

  task automatic test_in_basic();
    src_q = '{8'h11, 8'h22, 8'h33};
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'h11;
    start_txn(1, 1'b1, 1'b0);
    @(negedge clk_48);
    checks++; if (handshake !== ACK) begin failures++; $display("[TB] FAIL in_basic_hs: got %b expected %b", handshake, ACK); end
    checks++; if (data_toggle !== exp_tog(1, 1'b1)) begin failures++; $display("[TB] FAIL in_basic_toggle: got %b expected %b", data_toggle, exp_tog(1, 1'b1)); end
    tick();
    drive_in(1);
    checks++; if (strobe_cnt !== 3) begin failures++; $display("[TB] FAIL in_basic_strobes: got %0d expected 3", strobe_cnt); end
    checks++; if (got_matches(3) !== 1'b1) begin failures++; $display("[TB] FAIL in_basic_bytes: got %0d bytes, expected 11 22 33", got_q.size()); end
    checks++; if (stray_cnt !== 0) begin failures++; $display("[TB] FAIL in_basic_onehot: got %0d bad strobes expected 0", stray_cnt); end
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'h44;
    @(negedge clk_48);
    checks++; if (data_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL in_basic_eop_hold: got %b expected 0", data_in_valid); end
    tick();
    finish_txn(1'b1);
    model_success(1, 1'b1, 1'b0);
    checks++; if (commit_obs !== '0) begin failures++; $display("[TB] FAIL in_basic_no_commit: got %b expected 0", commit_obs); end
    start_txn(1, 1'b1, 1'b0);
    @(negedge clk_48);
    checks++; if (data_toggle !== exp_tog(1, 1'b1)) begin failures++; $display("[TB] FAIL in_basic_toggle_after: got %b expected %b", data_toggle, exp_tog(1, 1'b1)); end
    tick();
    finish_txn(1'b0);
    in_valid = '0;
  endtask

  task automatic test_max_pkt();
    src_q.delete();
    for (int i = 0; i < MAX_PKT + 16; i++) src_q.push_back(8'($urandom));
    in_valid[2] = 1'b1;
    start_txn(2, 1'b1, 1'b0);
    @(negedge clk_48);
    checks++; if (handshake !== ACK) begin failures++; $display("[TB] FAIL max_pkt_hs: got %b expected %b", handshake, ACK); end
    tick();
    drive_in(2);
    checks++; if (strobe_cnt !== MAX_PKT) begin failures++; $display("[TB] FAIL max_pkt_strobes: got %0d expected %0d", strobe_cnt, MAX_PKT); end
    checks++; if (got_matches(MAX_PKT) !== 1'b1) begin failures++; $display("[TB] FAIL max_pkt_bytes: got %0d bytes expected %0d matching", got_q.size(), MAX_PKT); end
    @(negedge clk_48);
    checks++; if (data_in_valid !== 1'b0 || in_valid[2] !== 1'b1) begin failures++; $display("[TB] FAIL max_pkt_stop: got valid %b expected 0", data_in_valid); end
    tick();
    finish_txn(1'b1);
    model_success(2, 1'b1, 1'b0);
    in_valid = '0;
  endtask

  task automatic test_setup_ep0();
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    out_ready[0] = 1'b1;
    ep_stall[0] = 1'b1;
    start_txn(0, 1'b0, 1'b1);
    @(negedge clk_48);
    checks++; if (handshake !== ACK) begin failures++; $display("[TB] FAIL setup_hs: got %b expected %b", handshake, ACK); end
    checks++; if (data_toggle !== exp_tog(0, 1'b0)) begin failures++; $display("[TB] FAIL setup_toggle: got %b expected %b", data_toggle, exp_tog(0, 1'b0)); end
    tick();
    drive_out(0, 8, 1'b1);
    checks++; if (strobe_cnt !== 8 || stray_cnt !== 0) begin failures++; $display("[TB] FAIL setup_strobes: got %0d (bad %0d) expected 8", strobe_cnt, stray_cnt); end
    checks++; if (got_matches(8) !== 1'b1) begin failures++; $display("[TB] FAIL setup_bytes: got %0d bytes expected 8 matching", got_q.size()); end
    finish_txn(1'b1);
    model_success(0, 1'b0, 1'b1);
    checks++; if (commit_obs !== 4'b0001 || setup_obs !== 1'b1) begin failures++; $display("[TB] FAIL setup_commit: got %b/%b expected 0001/1", commit_obs, setup_obs); end
    checks++; if (abort_obs !== '0) begin failures++; $display("[TB] FAIL setup_abort: got %b expected 0", abort_obs); end
    ep_stall = '0;
    in_valid[0] = 1'b1;
    start_txn(0, 1'b1, 1'b0);
    @(negedge clk_48);
    checks++; if (data_toggle !== exp_tog(0, 1'b1)) begin failures++; $display("[TB] FAIL setup_toggle_in: got %b expected %b", data_toggle, exp_tog(0, 1'b1)); end
    tick();
    finish_txn(1'b0);
    start_txn(0, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (data_toggle !== exp_tog(0, 1'b0)) begin failures++; $display("[TB] FAIL setup_toggle_out: got %b expected %b", data_toggle, exp_tog(0, 1'b0)); end
    tick();
    finish_txn(1'b0);
    in_valid = '0;
    out_ready = '0;
  endtask

  task automatic test_nak_stall();
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    out_ready = '0;
    start_txn(3, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (handshake !== NAK) begin failures++; $display("[TB] FAIL nak_hs: got %b expected %b", handshake, NAK); end
    tick();
    drive_out(3, 4, 1'b0);
    checks++; if (strobe_cnt !== 0 || stray_cnt !== 0) begin failures++; $display("[TB] FAIL nak_strobes: got %0d expected 0", strobe_cnt); end
    finish_txn(1'b0);
    checks++; if (abort_obs !== '0) begin failures++; $display("[TB] FAIL nak_abort: got %b expected 0", abort_obs); end
    out_ready[3] = 1'b1;
    start_txn(3, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (data_toggle !== exp_tog(3, 1'b0)) begin failures++; $display("[TB] FAIL nak_toggle_kept: got %b expected %b", data_toggle, exp_tog(3, 1'b0)); end
    tick();
    finish_txn(1'b0);
    out_ready = '1;
    start_txn(5, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (handshake !== STALL) begin failures++; $display("[TB] FAIL bad_ep_hs: got %b expected %b", handshake, STALL); end
    tick();
    drive_out(5, 4, 1'b0);
    checks++; if (strobe_cnt !== 0 || stray_cnt !== 0) begin failures++; $display("[TB] FAIL bad_ep_strobes: got %0d expected 0", strobe_cnt); end
    finish_txn(1'b0);
    out_ready = '0;
  endtask

  task automatic test_abort();
    src_q = '{8'h5A, 8'hC3};
    out_ready[1] = 1'b1;
    start_txn(1, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (handshake !== ACK) begin failures++; $display("[TB] FAIL abort_hs: got %b expected %b", handshake, ACK); end
    tick();
    drive_out(1, 2, 1'b1);
    checks++; if (strobe_cnt !== 2 || got_matches(2) !== 1'b1) begin failures++; $display("[TB] FAIL abort_strobes: got %0d expected 2", strobe_cnt); end
    finish_txn(1'b0);
    checks++; if (abort_obs !== 4'b0010 || commit_obs !== '0) begin failures++; $display("[TB] FAIL abort_pulse: got %b expected 0010", abort_obs); end
    start_txn(1, 1'b0, 1'b0);
    @(negedge clk_48);
    checks++; if (data_toggle !== exp_tog(1, 1'b0)) begin failures++; $display("[TB] FAIL abort_toggle_kept: got %b expected %b", data_toggle, exp_tog(1, 1'b0)); end
    tick();
    finish_txn(1'b0);
    checks++; if (abort_obs !== '0) begin failures++; $display("[TB] FAIL abort_empty: got %b expected 0", abort_obs); end
    out_ready = '0;
  endtask

  task automatic test_usb_rst();
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'h77;
    start_txn(1, 1'b1, 1'b0);
    data_strobe = 1'b1;
    tick();
    usb_rst = 1'b1;
    @(negedge clk_48);
    checks++; if (in_strobe !== '0) begin failures++; $display("[TB] FAIL usb_rst_strobe: got %b expected 0", in_strobe); end
    tick();
    usb_rst = 1'b0;
    model_clear();
    @(negedge clk_48);
    checks++; if (handshake !== NONE || data_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL usb_rst_idle: got hs %b valid %b expected 11 0", handshake, data_in_valid); end
    tick();
    tick();
    @(negedge clk_48);
    checks++; if (data_in_valid !== 1'b0 || in_strobe !== '0) begin failures++; $display("[TB] FAIL usb_rst_no_restart: got valid %b expected 0", data_in_valid); end
    data_strobe = 1'b0;
    tick();
    transaction_active = 1'b0;
    tick();
    tick();
    in_valid = '1;
    out_ready = '1;
    for (int ep = 0; ep < NUM_EP; ep++) begin
      for (int d = 0; d < 2; d++) begin
        start_txn(ep, d[0], 1'b0);
        @(negedge clk_48);
        checks++; if (data_toggle !== exp_tog(ep, d[0])) begin failures++; $display("[TB] FAIL usb_rst_toggle_ep%0d_dir%0d: got %b expected %b", ep, d, data_toggle, exp_tog(ep, d[0])); end
        tick();
        finish_txn(1'b0);
      end
    end
    in_valid = '0;
    out_ready = '0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int ep = $urandom_range(0, 5);
      bit dir = 1'($urandom_range(0, 1));
      bit stp = !dir && ($urandom_range(0, 3) == 0);
      int len = $urandom_range(1, 12);
      logic [1:0] hs;
      bit succ;
      ep_stall = NUM_EP'($urandom) & NUM_EP'($urandom);
      in_valid = NUM_EP'($urandom);
      out_ready = NUM_EP'($urandom);
      src_q.delete();
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      hs = exp_hs(ep, dir, stp);
      start_txn(ep, dir, stp);
      @(negedge clk_48);
      checks++; if (handshake !== hs) begin failures++; $display("[TB] FAIL rand%0d_hs: got %b expected %b", it, handshake, hs); end
      if (ep < NUM_EP) begin
        checks++; if (data_toggle !== exp_tog(ep, dir)) begin failures++; $display("[TB] FAIL rand%0d_toggle: got %b expected %b", it, data_toggle, exp_tog(ep, dir)); end
      end
      tick();
      if (dir) drive_in(ep);
      else drive_out(ep, len, hs == ACK);
      checks++; if (strobe_cnt !== ((hs == ACK) ? len : 0) || stray_cnt !== 0) begin failures++; $display("[TB] FAIL rand%0d_strobes: got %0d (bad %0d) expected %0d", it, strobe_cnt, stray_cnt, (hs == ACK) ? len : 0); end
      if (hs == ACK) begin
        checks++; if (got_matches(len) !== 1'b1) begin failures++; $display("[TB] FAIL rand%0d_bytes: got %0d bytes expected %0d matching", it, got_q.size(), len); end
      end
      succ = (hs == ACK) && ($urandom_range(0, 1) == 1);
      finish_txn(succ);
      checks++; if (commit_obs !== ((succ && !dir) ? onehot(ep) : '0) || setup_obs !== (succ && !dir && stp)) begin failures++; $display("[TB] FAIL rand%0d_commit: got %b/%b", it, commit_obs, setup_obs); end
      checks++; if (abort_obs !== ((!succ && !dir && hs == ACK) ? onehot(ep) : '0)) begin failures++; $display("[TB] FAIL rand%0d_abort: got %b", it, abort_obs); end
      if (succ) model_success(ep, dir, stp);
    end
    ep_stall = '0;
    in_valid = '0;
    out_ready = '0;
  endtask

  initial begin
    $display("[TB] starting usb_ep_arbiter bench");
    test_reset();
    test_in_basic();
    test_max_pkt();
    test_setup_ep0();
    test_nak_stall();
    test_abort();
    test_random();
    test_usb_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
